ttl_gate_bank: RTL and testbench

Parametrised, clocked replacement for the fixed-function multi-input gate packages such as the triple 3-input NAND. It evaluates CHANNELS independent INPUTS-wide gates of a selectable function. Each output then passes through an optional propagation-delay pipeline and an optional per-channel glitch filter. It sits wherever board-level glue logic is mapped into the synchronous FPGA clock domain, and gives deterministic, cycle-accurate gate delays instead of zero-delay combinational paths.

---
 rtl/ttl_pkg.sv | 36 +++
 rtl/ttl_glitch_filter.sv | 62 ++++++
 rtl/ttl_gate_bank.sv | 80 ++++++++
 tb/tb_ttl_gate_bank.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/ttl_pkg.sv
// Shared types and helpers for the clocked TTL-style gate bank.
package ttl_pkg;

  typedef enum logic [1:0] {
    GATE_NAND = 2'd0,
    GATE_AND  = 2'd1,
    GATE_NOR  = 2'd2,
    GATE_OR   = 2'd3
  } gate_func_e;

  localparam int unsigned MaxInputs = 8;

  // Evaluates the gate over the low n bits of vec; upper bits are ignored.
  function automatic logic gate_eval(gate_func_e func, logic [MaxInputs-1:0] vec,
                                     int unsigned n);
    logic [MaxInputs-1:0] mask;
    logic                 all_one;
    logic                 any_one;
    mask    = {MaxInputs{1'b1}} >> (MaxInputs - n);
    all_one = &(vec | ~mask);
    any_one = |(vec & mask);
    case (func)
      GATE_NAND: gate_eval = ~all_one;
      GATE_AND:  gate_eval = all_one;
      GATE_NOR:  gate_eval = ~any_one;
      GATE_OR:   gate_eval = any_one;
      default:   gate_eval = 1'b0;
    endcase
  endfunction

  // Output level of the gate with all inputs low.
  function automatic logic rst_level(gate_func_e func);
    rst_level = gate_eval(func, '0, 2);
  endfunction

endpackage

// File: rtl/ttl_glitch_filter.sv
// Per-channel persistence filter: cand must differ from y for FILTER enabled
// cycles before y follows. Also produces the one-cycle change flag.
module ttl_glitch_filter #(
  parameter int unsigned FILTER = 0,
  parameter logic        RST_Y  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic cand,
  output logic y,
  output logic chg
);

  logic y_prev_q;

  if (FILTER == 0) begin : g_bypass
    assign y = cand;
    // y is not a register here, so force chg low while reset is held.
    assign chg = (y ^ y_prev_q) & rst_n;
  end else begin : g_filter
    localparam logic [3:0] CntMax = 4'(FILTER - 1);

    logic       y_q, y_d;
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
      y_d   = y_q;
      cnt_d = cnt_q;
      if (cand == y_q) begin
        cnt_d = '0;
      end else if (cnt_q == CntMax) begin
        y_d   = cand;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        y_q   <= RST_Y;
        cnt_q <= '0;
      end else if (en) begin
        y_q   <= y_d;
        cnt_q <= cnt_d;
      end
    end

    assign y   = y_q;
    assign chg = y_q ^ y_prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_prev_q <= RST_Y;
    end else if (en) begin
      y_prev_q <= y;
    end
  end

endmodule

// File: rtl/ttl_gate_bank.sv
// Bank of CHANNELS identical INPUTS-wide gates with a clocked propagation
// delay line and optional per-channel glitch filtering.
module ttl_gate_bank
  import ttl_pkg::*;
#(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned INPUTS   = 3,
  parameter gate_func_e  FUNC     = GATE_NAND,
  parameter int unsigned LATENCY  = 1,
  parameter int unsigned FILTER   = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [CHANNELS*INPUTS-1:0] a,
  output logic [CHANNELS-1:0]        y,
  output logic [CHANNELS-1:0]        chg
);

  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $error("ttl_gate_bank: CHANNELS must be 1..16");
  end
  if (INPUTS < 2 || INPUTS > MaxInputs) begin : g_bad_inputs
    $error("ttl_gate_bank: INPUTS must be 2..8");
  end
  if (LATENCY > 8) begin : g_bad_latency
    $error("ttl_gate_bank: LATENCY must be 0..8");
  end
  if (FILTER > 15) begin : g_bad_filter
    $error("ttl_gate_bank: FILTER must be 0..15");
  end

  localparam logic                RstLvl = rst_level(FUNC);
  localparam logic [CHANNELS-1:0] RstY   = {CHANNELS{RstLvl}};

  logic [CHANNELS-1:0] f;
  logic [CHANNELS-1:0] cand;

  always_comb begin
    logic [MaxInputs-1:0] slice;
    f = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      slice              = '0;
      slice[INPUTS-1:0]  = a[c*INPUTS +: INPUTS];
      f[c]               = gate_eval(FUNC, slice, INPUTS);
    end
  end

  if (LATENCY == 0) begin : g_no_delay
    assign cand = f;
  end else begin : g_delay
    logic [CHANNELS-1:0] dly_q [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < LATENCY; i++) dly_q[i] <= RstY;
      end else if (en) begin
        dly_q[0] <= f;
        for (int i = 1; i < LATENCY; i++) dly_q[i] <= dly_q[i-1];
      end
    end

    assign cand = dly_q[LATENCY-1];
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    ttl_glitch_filter #(
      .FILTER(FILTER),
      .RST_Y (RstLvl)
    ) u_filter (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .cand (cand[c]),
      .y    (y[c]),
      .chg  (chg[c])
    );
  end

endmodule

// File: tb/tb_ttl_gate_bank.sv
// Directed bench: four gate-bank configurations driven side by side.
module tb_ttl_gate_bank;
  import ttl_pkg::*;

  logic clk;
  logic rst_n;

  logic [8:0] a_def, a_lat, a_flt;
  logic [7:0] a_nor;
  logic       en_lat;
  logic [2:0] y_def, chg_def, y_lat, chg_lat, y_flt, chg_flt;
  logic [3:0] y_nor, chg_nor;

  int checks = 0;
  int errors = 0;

  ttl_gate_bank #(
    .CHANNELS(3), .INPUTS(3), .FUNC(GATE_NAND), .LATENCY(1), .FILTER(0)
  ) u_def (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .a(a_def), .y(y_def), .chg(chg_def)
  );

  ttl_gate_bank #(
    .CHANNELS(3), .INPUTS(3), .FUNC(GATE_NAND), .LATENCY(3), .FILTER(0)
  ) u_lat (
    .clk(clk), .rst_n(rst_n), .en(en_lat), .a(a_lat), .y(y_lat), .chg(chg_lat)
  );

  ttl_gate_bank #(
    .CHANNELS(3), .INPUTS(3), .FUNC(GATE_NAND), .LATENCY(1), .FILTER(3)
  ) u_flt (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .a(a_flt), .y(y_flt), .chg(chg_flt)
  );

  ttl_gate_bank #(
    .CHANNELS(4), .INPUTS(2), .FUNC(GATE_NOR), .LATENCY(1), .FILTER(0)
  ) u_nor (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .a(a_nor), .y(y_nor), .chg(chg_nor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] exp_y, prev_y, pat;

    rst_n  = 1'b1;
    en_lat = 1'b1;
    a_def  = '0;
    a_lat  = '0;
    a_flt  = '0;
    a_nor  = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_y_def", 32'(y_def), 32'h7);
    check("rst_chg_def", 32'(chg_def), 32'h0);
    check("rst_y_lat", 32'(y_lat), 32'h7);
    check("rst_y_flt", 32'(y_flt), 32'h7);
    check("rst_y_nor", 32'(y_nor), 32'hf);
    check("rst_chg_nor", 32'(chg_nor), 32'h0);
    #19 rst_n = 1'b1;
    step(2);

    // NAND truth table, each channel offset so channels see different inputs.
    prev_y = 3'b111;
    for (int v = 0; v < 8; v++) begin
      for (int c = 0; c < 3; c++) begin
        pat = 3'((v + c) % 8);
        a_def[c*3 +: 3] = pat;
        exp_y[c] = (pat != 3'b111);
      end
      step(1);
      check($sformatf("nand_y_%0d", v), 32'(y_def), 32'(exp_y));
      check($sformatf("nand_chg_%0d", v), 32'(chg_def), 32'(exp_y ^ prev_y));
      prev_y = exp_y;
    end

    // Three-cycle propagation delay.
    a_lat[2:0] = 3'b111;
    step(2);
    check("lat_y_early", 32'(y_lat), 32'h7);
    step(1);
    check("lat_y_edge3", 32'(y_lat), 32'h6);
    check("lat_chg_edge3", 32'(chg_lat), 32'h1);
    step(1);
    check("lat_chg_clear", 32'(chg_lat), 32'h0);

    // Stall in the middle of the return transition.
    a_lat[2:0] = 3'b000;
    step(1);
    en_lat = 1'b0;
    step(5);
    check("stall_y_hold", 32'(y_lat), 32'h6);
    en_lat = 1'b1;
    step(1);
    check("stall_y_en2", 32'(y_lat), 32'h6);
    step(1);
    check("stall_y_en3", 32'(y_lat), 32'h7);
    check("stall_chg_en3", 32'(chg_lat), 32'h1);
    en_lat = 1'b0;
    step(2);
    check("stall_chg_hold", 32'(chg_lat), 32'h1);
    en_lat = 1'b1;
    step(1);
    check("stall_chg_clear", 32'(chg_lat), 32'h0);

    // Short pulses on ch1 must never reach y.
    for (int p = 1; p <= 2; p++) begin
      a_flt[5:3] = 3'b111;
      for (int i = 0; i < 6; i++) begin
        if (i == p) a_flt[5:3] = 3'b000;
        step(1);
        check($sformatf("flt_pulse%0d_e%0d", p, i + 1), 32'(y_flt), 32'h7);
      end
    end

    // Three-cycle pulse gets through four edges after onset.
    a_flt[5:3] = 3'b111;
    step(3);
    check("flt_p3_before", 32'(y_flt), 32'h7);
    a_flt[5:3] = 3'b000;
    step(1);
    check("flt_p3_y", 32'(y_flt), 32'h5);
    check("flt_p3_chg", 32'(chg_flt), 32'h2);
    step(3);
    check("flt_p3_return", 32'(y_flt), 32'h7);
    step(2);

    // Hold low output, then start counting back up and reset mid-count.
    a_flt[5:3] = 3'b111;
    step(6);
    check("flt_hold_y", 32'(y_flt), 32'h5);
    a_flt[5:3] = 3'b000;
    step(3);
    check("flt_cnt2_y", 32'(y_flt), 32'h5);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_y_flt", 32'(y_flt), 32'h7);
    check("async_rst_chg_flt", 32'(chg_flt), 32'h0);
    check("async_rst_y_lat", 32'(y_lat), 32'h7);
    a_flt[5:3] = 3'b111;
    #2 rst_n = 1'b1;
    step(3);
    check("post_rst_y_e3", 32'(y_flt), 32'h7);
    step(1);
    check("post_rst_y_e4", 32'(y_flt), 32'h5);
    check("post_rst_chg_e4", 32'(chg_flt), 32'h2);

    // NOR 4x2.
    check("nor_idle_y", 32'(y_nor), 32'hf);
    a_nor[5:4] = 2'b01;
    step(1);
    check("nor_ch2_y", 32'(y_nor), 32'hb);
    check("nor_ch2_chg", 32'(chg_nor), 32'h4);
    a_nor = 8'b00_01_00_10;
    step(1);
    check("nor_mix_y", 32'(y_nor), 32'ha);
    check("nor_mix_chg", 32'(chg_nor), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
